// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//
// Purpose:
//   Turns parallel words into a serial bit stream, one bit per clock. The
//   stream feeds a downstream "001" sequence detector. Words can follow each
//   other with no gap. When no payload bit is present, the line rests at
//   IDLE_BIT so the detector stays in its start state.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//   IDLE_BIT   level driven on sout when no payload bit is valid
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   din          in   parallel word to serialize
//   din_valid    in   din holds a word to transfer
//   din_ready    out  block can accept din this cycle (combinational)
//   sout         out  serial bit stream (registered)
//   sout_valid   out  sout carries a payload bit this cycle (registered)
//   frame_start  out  one-cycle pulse with the first bit of each word (registered)
//   busy         out  high while a word is being shifted (registered)
// ---------------------------------------------------------------------------
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             sout_next;
  logic             valid_next;
  logic             frame_next;
  logic             busy_next;
  logic             last_bit;
  logic             accept;

  // In SHIFT, cnt is the index of the bit that sout is showing right now.
  // So the final bit of a word is on the line when cnt == LAST_CNT. That is
  // the only SHIFT cycle in which a new word may be loaded.
  assign last_bit = (cnt == LAST_CNT);

  // Next-state and next-output logic.
  // The registered sout always carries the bit being emitted. shreg holds
  // the bits that have not been emitted yet, pre-shifted so the next bit to
  // send always sits at the outgoing end. When a word is loaded, its first
  // bit goes straight to sout and the remainder goes into shreg. This gives
  // the one-edge latency and lets the last bit of one word be followed by
  // the first bit of the next word with no gap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    sout_next  = IDLE_BIT;
    valid_next = 1'b0;
    frame_next = 1'b0;
    busy_next  = 1'b0;
    din_ready  = 1'b0;

    case (state)
      IDLE:    din_ready = 1'b1;
      SHIFT:   din_ready = last_bit;
      default: din_ready = 1'b0;
    endcase

    // The block refuses words while reset is asserted, so no word can slip
    // in on a reset edge.
    if (!rst) begin
      din_ready = 1'b0;
    end

    accept = din_ready && din_valid;

    if (accept) begin
      state_next = SHIFT;
      cnt_next   = '0;
      valid_next = 1'b1;
      frame_next = 1'b1;
      busy_next  = 1'b1;
      if (MSB_FIRST) begin
        sout_next  = din[WIDTH-1];
        shreg_next = {din[WIDTH-2:0], 1'b0};
      end else begin
        sout_next  = din[0];
        shreg_next = {1'b0, din[WIDTH-1:1]};
      end
    end else if ((state == SHIFT) && !last_bit) begin
      cnt_next   = cnt + CNT_W'(1);
      valid_next = 1'b1;
      busy_next  = 1'b1;
      if (MSB_FIRST) begin
        sout_next  = shreg[WIDTH-1];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end else begin
        sout_next  = shreg[0];
        shreg_next = {1'b0, shreg[WIDTH-1:1]};
      end
    end else begin
      // Either idle with nothing offered, or the last bit just went out and
      // no follow-on word arrived. The line drops back to its resting level.
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // State register and registered outputs.
  // Reset throws away any word in flight. After reset, the next accepted
  // word starts cleanly from its first bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      sout        <= IDLE_BIT;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shreg       <= shreg_next;
      sout        <= sout_next;
      sout_valid  <= valid_next;
      frame_start <= frame_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//
// Purpose:
//   Directed testbench for seq_serializer. It drives two instances:
//   - dut:     MSB-first, the default configuration
//   - dut_lsb: LSB-first
//   Every expected value is a hand-computed constant word, indexed bit by bit.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       busy;

  logic [7:0] din_l;
  logic       din_valid_l;
  logic       din_ready_l;
  logic       sout_l;
  logic       sout_valid_l;
  logic       frame_start_l;
  logic       busy_l;

  int checks;
  int failures;

  logic [7:0]  word;
  logic [15:0] pair;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .busy       (busy)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din_l),
    .din_valid  (din_valid_l),
    .din_ready  (din_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .frame_start(frame_start_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks all outputs of the MSB-first instance at once.
  task automatic check_msb(input string tag, input logic exp_sout, input logic exp_valid,
                           input logic exp_frame, input logic exp_busy,
                           input logic exp_ready);
    check_output({tag, ".sout"}, 32'(sout), 32'(exp_sout));
    check_output({tag, ".sout_valid"}, 32'(sout_valid), 32'(exp_valid));
    check_output({tag, ".frame_start"}, 32'(frame_start), 32'(exp_frame));
    check_output({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check_output({tag, ".din_ready"}, 32'(din_ready), 32'(exp_ready));
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    din         = 8'hFF;
    din_valid   = 1'b1;
    din_l       = 8'h00;
    din_valid_l = 1'b0;

    // Hold reset for three edges with a word offered; nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_msb($sformatf("rst_hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Release reset with nothing offered; the line must stay idle.
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_msb($sformatf("post_rst%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Single word 0x24 sent MSB first, followed by a return to idle.
    word      = 8'h24;
    din       = word;
    din_valid = 1'b1;
    #1;
    check_output("single.ready_idle", 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
    din       = 8'h00;
    #1;
    for (int i = 0; i < 8; i++) begin
      check_msb($sformatf("single.b%0d", i), word[7-i], 1'b1, (i == 0), 1'b1, (i == 7));
      tick();
    end
    check_msb("single.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stall while busy: pulses at cnt 2 and cnt 5 must be ignored.
    word      = 8'h5A;
    din       = word;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5) begin
        din       = 8'hFF;
        din_valid = 1'b1;
        #1;
      end
      check_msb($sformatf("stall.b%0d", i), word[7-i], 1'b1, (i == 0), 1'b1, (i == 7));
      tick();
      din_valid = 1'b0;
      #1;
    end
    check_msb("stall.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back words 0xA5 then 0x3C, with no gap between them.
    pair      = 16'hA53C;
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din = 8'h3C;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        din_valid = 1'b0;
        #1;
      end
      check_msb($sformatf("b2b.b%0d", i), pair[15-i], 1'b1, (i == 0 || i == 8), 1'b1,
                (i == 7 || i == 15));
      tick();
    end
    check_msb("b2b.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the fourth bit of 0xF0 drops the rest of that word.
    word      = 8'hF0;
    din       = word;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_msb($sformatf("midrst.b%0d", i), word[7-i], 1'b1, (i == 0), 1'b1, 1'b0);
      tick();
    end
    rst = 1'b0;
    #1;
    check_output("midrst.ready_in_rst", 32'(din_ready), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check_msb("midrst.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // The next word after reset is sent in full.
    word      = 8'h81;
    din       = word;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check_msb($sformatf("postrst.b%0d", i), word[7-i], 1'b1, (i == 0), 1'b1, (i == 7));
      tick();
    end
    check_msb("postrst.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first instance: words 0x01 and 0xB2, each sent separately.
    check_output("lsb.idle_sout", 32'(sout_l), 32'd1);
    check_output("lsb.idle_valid", 32'(sout_valid_l), 32'd0);
    for (int w = 0; w < 2; w++) begin
      word        = (w == 0) ? 8'h01 : 8'hB2;
      din_l       = word;
      din_valid_l = 1'b1;
      tick();
      din_valid_l = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
        check_output($sformatf("lsb%0d.b%0d", w, i), 32'(sout_l), 32'(word[i]));
        check_output($sformatf("lsb%0d.v%0d", w, i), 32'(sout_valid_l), 32'd1);
        check_output($sformatf("lsb%0d.fs%0d", w, i), 32'(frame_start_l), 32'(i == 0));
        tick();
      end
      check_output($sformatf("lsb%0d.after_sout", w), 32'(sout_l), 32'd1);
      check_output($sformatf("lsb%0d.after_busy", w), 32'(busy_l), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
